// File: rtl/ex_hazard_sequencer_if.sv
// Hazard-unit bundle: register addresses and controls from the pipeline (master),
// plus the forwarding, stall, flush and event-counter outputs of the sequencer (slave).
interface ex_hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic [4:0]       Rs1_E;
    logic [4:0]       Rs2_E;
    logic [4:0]       RD_E;
    logic [4:0]       RD_M;
    logic [4:0]       RD_W;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE;
    logic             PCSrcE;
    logic             MultiCycleE;
    logic             ClrCnt;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             MC_Done;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE, ClrCnt,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
        input  MC_Done, StallCount, FlushCount
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE, ClrCnt,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
        output MC_Done, StallCount, FlushCount
    );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls, branch flushes,
// fixed-latency multi-cycle op sequencing and saturating stall/flush event counters.
module ex_hazard_sequencer #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_hazard_sequencer_if.slave hz
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [7:0] LOAD_CNT = 8'(MC_LATENCY - 2);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [4:0] w_rs_e  [2];
    logic [1:0] w_fwd   [2];
    logic       w_lw_stall;
    logic       w_mc_stall;
    logic       w_mc_done;
    logic       w_stall_f;

    assign w_rs_e[0] = hz.Rs1_E;
    assign w_rs_e[1] = hz.Rs2_E;

    // Memory stage wins over writeback; x0 never matches because rd must be nonzero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                w_fwd[gi] = 2'b00;
                if (hz.RegWriteM && (hz.RD_M != 5'd0) && (hz.RD_M == w_rs_e[gi])) begin
                    w_fwd[gi] = 2'b10;
                end else if (hz.RegWriteW && (hz.RD_W != 5'd0) && (hz.RD_W == w_rs_e[gi])) begin
                    w_fwd[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign w_lw_stall = hz.ResultSrcE && (hz.RD_E != 5'd0) &&
                        ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));

    // The IDLE term is gated by reset so StallE falls the moment reset asserts.
    assign w_mc_stall = (r_state == ST_IDLE) ? (hz.MultiCycleE && rst) : (r_cnt != 8'd0);
    assign w_mc_done  = (r_state == ST_BUSY) && (r_cnt == 8'd0);
    assign w_stall_f  = w_lw_stall || w_mc_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (hz.MultiCycleE) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= LOAD_CNT;
                    end
                end
                ST_BUSY: begin
                    // MultiCycleE is ignored here so the held op cannot retrigger itself.
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (hz.ClrCnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (hz.PCSrcE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.ForwardA_E = w_fwd[0];
    assign hz.ForwardB_E = w_fwd[1];
    assign hz.StallF     = w_stall_f;
    assign hz.StallD     = w_stall_f;
    assign hz.StallE     = w_mc_stall;
    assign hz.FlushD     = hz.PCSrcE;
    assign hz.FlushE     = (w_lw_stall || hz.PCSrcE) && !w_mc_stall;
    assign hz.MC_Done    = w_mc_done;
    assign hz.StallCount = r_stall_cnt;
    assign hz.FlushCount = r_flush_cnt;
endmodule
